// File: rtl/fb_arbiter_if.sv
// Port bundle for fb_arbiter: rasterizer write, scanout read, clear engine
// control, and the registered frame-buffer side.
interface fb_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_ready;

  logic [ADDR_W-1:0] s_addr;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_rdata;
  logic              s_rvalid;

  logic              clear_start;
  logic [DATA_W-1:0] clear_color;
  logic              clear_busy;
  logic              clear_done;
  logic              oob_err;

  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;
  logic              fb_we;
  logic              fb_re;
  logic [DATA_W-1:0] fb_rdata;

  // Environment side: requesters plus the frame buffer itself.
  modport master (
    output r_addr, r_data, r_valid, s_addr, s_valid, clear_start, clear_color, fb_rdata,
    input  r_ready, s_ready, s_rdata, s_rvalid, clear_busy, clear_done, oob_err,
           fb_addr, fb_data, fb_we, fb_re
  );

  modport slave (
    input  r_addr, r_data, r_valid, s_addr, s_valid, clear_start, clear_color, fb_rdata,
    output r_ready, s_ready, s_rdata, s_rvalid, clear_busy, clear_done, oob_err,
           fb_addr, fb_data, fb_we, fb_re
  );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: scanout reads first, then round-robin
// between rasterizer writes and the full-buffer clear engine.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | clear engine quiet, accepts clear_start
// ST_CLEAR | sweeping cnt_q from 0 to FB_DEPTH-1, one write per grant
module fb_arbiter #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 8,
  parameter int FB_DEPTH = 76800
) (
  input logic        clk,
  input logic        reset,
  fb_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic              done_q, done_d;

  logic              rr_last_q, rr_last_d;  // 1: clear engine was the last writer granted
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [DATA_W-1:0] fb_data_q, fb_data_d;
  logic              fb_we_q, fb_we_d;
  logic              fb_re_q;
  logic              s_rvalid_q;
  logic              oob_q, oob_d;

  logic              clr_req, clr_gnt, r_gnt, s_gnt, r_in_range;

  always_comb begin
    s_gnt      = bus.s_valid;
    clr_req    = (state_q == ST_CLEAR);
    r_gnt      = bus.r_valid && !bus.s_valid && (!clr_req || rr_last_q);
    clr_gnt    = clr_req && !bus.s_valid && (!bus.r_valid || !rr_last_q);
    r_in_range = (bus.r_addr <= LAST_ADDR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      color_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.clear_start) begin
          color_d = bus.clear_color;
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (clr_gnt) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    rr_last_d = rr_last_q;
    // Out-of-range rasterizer writes complete the handshake but never reach the buffer.
    fb_we_d   = (r_gnt && r_in_range) || clr_gnt;
    oob_d     = oob_q || (r_gnt && !r_in_range);
    if (s_gnt) begin
      fb_addr_d = bus.s_addr;
    end else if (r_gnt) begin
      fb_addr_d = bus.r_addr;
      fb_data_d = bus.r_data;
      rr_last_d = 1'b0;
    end else if (clr_gnt) begin
      fb_addr_d = cnt_q;
      fb_data_d = color_q;
      rr_last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last_q  <= 1'b1;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      fb_we_q    <= 1'b0;
      fb_re_q    <= 1'b0;
      s_rvalid_q <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      rr_last_q  <= rr_last_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      fb_we_q    <= fb_we_d;
      fb_re_q    <= s_gnt;
      s_rvalid_q <= fb_re_q;
      oob_q      <= oob_d;
    end
  end

  assign bus.r_ready    = r_gnt;
  assign bus.s_ready    = s_gnt;
  assign bus.s_rvalid   = s_rvalid_q;
  // Gated so the read-data port is quiet whenever no read result is presented.
  assign bus.s_rdata    = s_rvalid_q ? bus.fb_rdata : '0;
  assign bus.clear_busy = clr_req;
  assign bus.clear_done = done_q;
  assign bus.oob_err    = oob_q;
  assign bus.fb_addr    = fb_addr_q;
  assign bus.fb_data    = fb_data_q;
  assign bus.fb_we      = fb_we_q;
  assign bus.fb_re      = fb_re_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a 16-entry frame buffer: arbitration
// vector table plus hand-written read-latency, clear and reset sequences.
module tb_fb_arbiter;

  localparam int AW    = 17;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural buffer: synchronous read, preset contents mem[i] = i ^ 0x3B (mem[7] = 0x3C).
  logic [DW-1:0] mem [32];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i) ^ 8'h3B;
      bus.fb_rdata <= '0;
    end else begin
      if (bus.fb_we) mem[bus.fb_addr[4:0]] <= bus.fb_data;
      if (bus.fb_re) bus.fb_rdata <= mem[bus.fb_addr[4:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.r_valid     = 1'b0;
    bus.r_addr      = '0;
    bus.r_data      = '0;
    bus.s_valid     = 1'b0;
    bus.s_addr      = '0;
    bus.clear_start = 1'b0;
    bus.clear_color = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " fb_we"},      32'(bus.fb_we),      32'd0);
    chk({tag, " fb_re"},      32'(bus.fb_re),      32'd0);
    chk({tag, " fb_addr"},    32'(bus.fb_addr),    32'd0);
    chk({tag, " fb_data"},    32'(bus.fb_data),    32'd0);
    chk({tag, " s_rvalid"},   32'(bus.s_rvalid),   32'd0);
    chk({tag, " s_rdata"},    32'(bus.s_rdata),    32'd0);
    chk({tag, " clear_busy"}, 32'(bus.clear_busy), 32'd0);
    chk({tag, " clear_done"}, 32'(bus.clear_done), 32'd0);
    chk({tag, " oob_err"},    32'(bus.oob_err),    32'd0);
    chk({tag, " r_ready"},    32'(bus.r_ready),    32'd0);
    chk({tag, " s_ready"},    32'(bus.s_ready),    32'd0);
  endtask

  typedef struct {
    logic          s_valid;
    logic [AW-1:0] s_addr;
    logic          r_valid;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          e_s_ready;
    logic          e_r_ready;
    logic          e_we;
    logic          e_re;
    logic          chk_addr;
    logic [AW-1:0] e_addr;
    logic          chk_data;
    logic [DW-1:0] e_data;
    logic          e_oob;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int k, exp_a, done_cnt, done_k, first_we_k, bad, nclr;
    bit found;

    // s_v  s_a    r_v  r_a    r_d     s_rdy r_rdy we re  ca  e_a    cd  e_d     oob
    vecs[0] = '{1'b0, 17'd0,  1'b1, 17'd5,  8'hAB, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 17'd5,  1'b1, 8'hAB, 1'b0};
    vecs[1] = '{1'b0, 17'd0,  1'b0, 17'd0,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'd0,  1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 17'd7,  1'b1, 17'd9,  8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 17'd7,  1'b0, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 17'd0,  1'b1, 17'd9,  8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 17'd9,  1'b1, 8'h55, 1'b0};
    vecs[4] = '{1'b0, 17'd0,  1'b1, 17'd16, 8'h99, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 17'd0,  1'b0, 8'h00, 1'b1};
    vecs[5] = '{1'b1, 17'd20, 1'b0, 17'd0,  8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 17'd20, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{1'b1, 17'd3,  1'b0, 17'd0,  8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 17'd3,  1'b0, 8'h00, 1'b1};
    vecs[7] = '{1'b0, 17'd0,  1'b1, 17'd15, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 17'd15, 1'b1, 8'hFF, 1'b1};

    reset = 1'b0;
    drive_idle();
    #23;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Arbitration vector table, clear engine idle.
    for (int v = 0; v < 8; v++) begin
      bus.s_valid = vecs[v].s_valid;
      bus.s_addr  = vecs[v].s_addr;
      bus.r_valid = vecs[v].r_valid;
      bus.r_addr  = vecs[v].r_addr;
      bus.r_data  = vecs[v].r_data;
      #1;
      chk($sformatf("v%0d s_ready", v), 32'(bus.s_ready), 32'(vecs[v].e_s_ready));
      chk($sformatf("v%0d r_ready", v), 32'(bus.r_ready), 32'(vecs[v].e_r_ready));
      @(negedge clk);
      chk($sformatf("v%0d fb_we", v), 32'(bus.fb_we), 32'(vecs[v].e_we));
      chk($sformatf("v%0d fb_re", v), 32'(bus.fb_re), 32'(vecs[v].e_re));
      if (vecs[v].chk_addr) chk($sformatf("v%0d fb_addr", v), 32'(bus.fb_addr), 32'(vecs[v].e_addr));
      if (vecs[v].chk_data) chk($sformatf("v%0d fb_data", v), 32'(bus.fb_data), 32'(vecs[v].e_data));
      chk($sformatf("v%0d oob_err", v), 32'(bus.oob_err), 32'(vecs[v].e_oob));
    end
    drive_idle();

    // Sticky out-of-range flag survives idle cycles.
    repeat (10) @(negedge clk);
    chk("oob sticky", 32'(bus.oob_err), 32'd1);
    chk("oob idle fb_we", 32'(bus.fb_we), 32'd0);

    // Read at 7 (holds 0x3C) competing with a pending rasterizer write.
    bus.s_valid = 1'b1; bus.s_addr = 17'd7;
    bus.r_valid = 1'b1; bus.r_addr = 17'd2; bus.r_data = 8'h44;
    #1;
    chk("rd N s_ready", 32'(bus.s_ready), 32'd1);
    chk("rd N r_ready", 32'(bus.r_ready), 32'd0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk("rd N+1 fb_re", 32'(bus.fb_re), 32'd1);
    chk("rd N+1 fb_addr", 32'(bus.fb_addr), 32'd7);
    chk("rd N+1 fb_we", 32'(bus.fb_we), 32'd0);
    #1;
    chk("rd N+1 r_ready", 32'(bus.r_ready), 32'd1);
    @(negedge clk);
    bus.r_valid = 1'b0;
    chk("rd N+2 s_rvalid", 32'(bus.s_rvalid), 32'd1);
    chk("rd N+2 s_rdata", 32'(bus.s_rdata), 32'h3C);
    chk("rd N+2 fb_re", 32'(bus.fb_re), 32'd0);
    chk("rd N+2 fb_we", 32'(bus.fb_we), 32'd1);
    chk("rd N+2 fb_addr", 32'(bus.fb_addr), 32'd2);
    chk("rd N+2 fb_data", 32'(bus.fb_data), 32'h44);
    @(negedge clk);
    chk("rd N+3 s_rvalid", 32'(bus.s_rvalid), 32'd0);
    drive_idle();
    repeat (2) @(negedge clk);

    // Lone clear with colour 0x11; a second start mid-clear must be ignored.
    bus.clear_start = 1'b1; bus.clear_color = 8'h11;
    exp_a = 0; done_cnt = 0; done_k = 0; first_we_k = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.clear_start = 1'b0;
        chk("clr busy rise", 32'(bus.clear_busy), 32'd1);
      end
      if (k == 5) begin bus.clear_start = 1'b1; bus.clear_color = 8'h22; end
      if (k == 6) bus.clear_start = 1'b0;
      if (bus.fb_we) begin
        if (first_we_k == 0) first_we_k = k;
        chk($sformatf("clr addr k%0d", k), 32'(bus.fb_addr), 32'(exp_a));
        chk($sformatf("clr data k%0d", k), 32'(bus.fb_data), 32'h11);
        exp_a++;
      end
      if (bus.clear_done) begin
        done_cnt++;
        done_k = k;
        chk("clr busy at done", 32'(bus.clear_busy), 32'd0);
      end
    end
    chk("clr first write cycle", 32'(first_we_k), 32'd2);
    chk("clr write count", 32'(exp_a), 32'd16);
    chk("clr done count", 32'(done_cnt), 32'd1);
    chk("clr done cycle", 32'(done_k), 32'd17);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== 8'h11) bad++;
    chk("clr mem contents", 32'(bad), 32'd0);

    // Clear with the rasterizer requesting continuously: grants alternate r, clear, r, ...
    bus.clear_start = 1'b1; bus.clear_color = 8'h22;
    bad = 0; done_k = 0; nclr = 0;
    for (k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.fb_we && bus.fb_data == 8'h22) nclr++;
      if (bus.clear_done && done_k == 0) done_k = k;
      if (k == 1) begin
        bus.clear_start = 1'b0;
        bus.r_valid = 1'b1; bus.r_addr = 17'd3; bus.r_data = 8'h77;
      end
      if (done_k != 0) break;
      #1;
      if (bus.r_ready !== ((k % 2) == 1)) bad++;
    end
    drive_idle();
    chk("rr alternation errors", 32'(bad), 32'd0);
    chk("rr clear done cycle", 32'(done_k), 32'd33);
    chk("rr clear write count", 32'(nclr), 32'd16);
    repeat (3) @(negedge clk);

    // Reset in the middle of a clear.
    bus.clear_start = 1'b1; bus.clear_color = 8'h55;
    @(negedge clk);
    bus.clear_start = 1'b0;
    found = 1'b0;
    for (k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (bus.fb_we && bus.fb_addr == 17'd8) found = 1'b1;
    end
    chk("mid-clear addr 8 reached", 32'(found), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk_all_zero("async reset");
    @(negedge clk);
    reset = 1'b1;
    done_cnt = 0; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.clear_done) done_cnt++;
      if (bus.clear_busy) bad++;
    end
    chk("post-reset clear_done", 32'(done_cnt), 32'd0);
    chk("post-reset clear_busy", 32'(bad), 32'd0);

    bus.clear_start = 1'b1; bus.clear_color = 8'h66;
    @(negedge clk);
    bus.clear_start = 1'b0;
    found = 1'b0;
    for (k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (bus.fb_we) found = 1'b1;
    end
    chk("restart write seen", 32'(found), 32'd1);
    chk("restart addr", 32'(bus.fb_addr), 32'd0);
    chk("restart data", 32'(bus.fb_data), 32'h66);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Frame-buffer port controller that shares the single-port frame buffer between three requesters: the rasterizer pixel-write stream, a display scanout read stream, and a built-in clear engine that fills the whole buffer with one colour. It sits between the rasterizer and `frame_buffer`. It grants at most one access per cycle and drives registered write/read strobes to the buffer. It returns read data to scanout with fixed latency.

## Interface
- `ADDR_W`, 17, frame-buffer address width
- `DATA_W`, 8, pixel colour width
- `FB_DEPTH`, 76800, number of valid addresses (320x240)

- `clk` in 1: single clock, all logic rising-edge
- `reset` in 1: asynchronous, active-low reset
- `r_addr` in ADDR_W: rasterizer write address
- `r_data` in DATA_W: rasterizer write colour
- `r_valid` in 1: rasterizer write request
- `r_ready` out 1: rasterizer write accepted this cycle
- `s_addr` in ADDR_W: scanout read address
- `s_valid` in 1: scanout read request
- `s_ready` out 1: scanout read accepted this cycle
- `s_rdata` out DATA_W: read data, equals `fb_rdata`
- `s_rvalid` out 1: `s_rdata` valid
- `clear_start` in 1: single-cycle pulse to begin a full clear
- `clear_color` in DATA_W: fill colour, sampled on accepted `clear_start`
- `clear_busy` out 1: clear in progress
- `clear_done` out 1: single-cycle pulse when the clear completes
- `oob_err` out 1: sticky flag, set when a rasterizer write address is ≥ FB_DEPTH
- `fb_addr` out ADDR_W: buffer address, registered
- `fb_data` out DATA_W: buffer write data, registered
- `fb_we` out 1: buffer write strobe, registered
- `fb_re` out 1: buffer read strobe, registered
- `fb_rdata` in DATA_W: buffer synchronous read data, valid the cycle after `fb_re`

## Operation
- Handshake: a transfer occurs when valid and ready are both high on a rising edge.
  - Requesters hold address and data stable while valid is high and ready is low.
  - `r_ready` and `s_ready` are combinational from the current requests and arbiter state.
- Arbitration, evaluated each cycle:
  - Scanout read has absolute priority: `s_ready = s_valid`.
  - When there is no read request, the two writers (rasterizer, clear engine) share the port round-robin.
  - A 1-bit `rr_last` register records the last granted writer. When both writers request, the writer that was not last granted wins.
  - A lone requesting writer is always granted.
  - `rr_last` updates only on a write grant. Its reset value is "clear", so the rasterizer wins the first tie.
- Clear engine:
  - States: IDLE and CLEAR.
  - In IDLE, `clear_start` latches `clear_color`, sets the counter to 0, and moves to CLEAR.
  - In CLEAR, the engine requests every cycle. Each grant writes the counter value as the address and increments the counter.
  - The grant at address FB_DEPTH-1 returns the engine to IDLE.
  - `clear_start` is ignored while in CLEAR.
- Rasterizer writes granted during a clear are performed. Ordering relative to the clear sweep is not guaranteed; the command path waits for `clear_done` before drawing.
- Out-of-range rasterizer write (`r_addr` ≥ FB_DEPTH):
  - The handshake completes normally (`r_ready` high per arbitration).
  - No `fb_we` is issued.
  - `oob_err` is set and stays set until reset.
- Scanout reads are not range-checked. The address passes to the buffer as given.

## Timing
- Reset values: all outputs 0, `rr_last` = clear, clear engine in IDLE, counter 0, no read in flight.
  - Reset asserted mid-clear aborts the clear with no `clear_done`.
  - Reset asserted mid-read drops the pending `s_rvalid`.
- Write granted in cycle N: `fb_addr`/`fb_data` hold the granted values and `fb_we`=1 during cycle N+1. `fb_we`=0 in any cycle with no write grant in the previous cycle.
- Read granted in cycle N:
  - `fb_re`=1 and `fb_addr`=`s_addr` during cycle N+1.
  - `s_rvalid`=1 during N+2 (`fb_re` delayed one register), with `s_rdata`=`fb_rdata`.
  - Back-to-back reads give one `s_rvalid` per cycle.
- `fb_we` and `fb_re` are never high in the same cycle.
- `clear_busy` goes high in the cycle after the accepted `clear_start`.
- `clear_done` pulses, and `clear_busy` falls, in the cycle after the FB_DEPTH-1 grant.
  - A `clear_start` arriving in the `clear_done` cycle is accepted.
- Minimum clear time is FB_DEPTH cycles. Read traffic can starve writes indefinitely; scanout burst length is bounded by the display controller.

## Test plan
- Single rasterizer write (addr 5, data 0xAB), no other traffic:
  - `r_ready`=1 the same cycle.
  - Next cycle: `fb_we`=1, `fb_addr`=5, `fb_data`=0xAB.
  - Following cycle: `fb_we`=0.
- Read at addr 7 with the buffer holding 0x3C while a rasterizer write is also pending:
  - `s_ready`=1 and `r_ready`=0 in cycle N.
  - `fb_re`=1 in N+1.
  - `s_rvalid`=1 with `s_rdata`=0x3C in N+2.
  - The write is granted in N+1.
- FB_DEPTH=16, `clear_start` with colour 0x11 and no other traffic:
  - Addresses 0..15 are each written with 0x11 on consecutive cycles.
  - `clear_done` pulses exactly once, 17 cycles after the `clear_start` cycle.
  - A second `clear_start` issued mid-clear is ignored.
- Clear running with `r_valid` held high continuously:
  - Grants alternate rasterizer, clear, rasterizer, …
  - The clear completes in 2×FB_DEPTH cycles.
- Rasterizer write to addr FB_DEPTH: `r_ready`=1, no `fb_we`, `oob_err`=1 and still 1 after 10 idle cycles.
- `reset` asserted at clear address 8 of 16:
  - All outputs are 0 immediately (asynchronous).
  - After release: `clear_busy`=0 and there is no `clear_done`.
  - A new clear then restarts at address 0.
